// File: rtl/sim_uart_in_source_if.sv
// Host-push / SoC-pull bundle for the simulation UART input source.
// The master side is the host plus SoC strobe; the slave side is the FIFO block.
interface sim_uart_in_source_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          push_valid;
    logic          push_ready;
    logic [7:0]    push_data;
    logic          io_uart_in_valid;
    logic [7:0]    io_uart_in_ch;
    logic [CW-1:0] count;
    logic [31:0]   empty_reads;

    modport master (
        output push_valid,
        output push_data,
        output io_uart_in_valid,
        input  push_ready,
        input  io_uart_in_ch,
        input  count,
        input  empty_reads
    );

    modport slave (
        input  push_valid,
        input  push_data,
        input  io_uart_in_valid,
        output push_ready,
        output io_uart_in_ch,
        output count,
        output empty_reads
    );
endinterface

// File: rtl/sim_uart_in_source.sv
// Simulation-only UART input source: host pushes bytes into a FIFO, the SoC pulls one
// byte per strobe with zero latency, gated by a post-reset hold-off window.
module sim_uart_in_source #(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned HOLDOFF_CYCLES = 1000,
    parameter logic [7:0]  EMPTY_CHAR     = 8'hFF
) (
    input logic                clock,
    input logic                reset_n,
    sim_uart_in_source_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [0:0] ST_HOLDOFF = 1'b0;
    localparam logic [0:0] ST_ACTIVE  = 1'b1;
    // A zero-length hold-off skips straight to ACTIVE out of reset.
    localparam logic [0:0] ST_RESET   = (HOLDOFF_CYCLES == 0) ? ST_ACTIVE : ST_HOLDOFF;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   empty_reads_q;
    logic [31:0]   holdoff_cnt_q;
    logic [0:0]    state_q, state_d;

    logic push_ready;
    logic deliver;
    logic push;
    logic pop;
    logic empty_read;

    always_comb begin
        push_ready = reset_n && (count_q != CW'(DEPTH));
        deliver    = reset_n && (state_q == ST_ACTIVE) && (count_q != '0);
        push       = bus.push_valid && push_ready;
        pop        = bus.io_uart_in_valid && deliver;
        empty_read = bus.io_uart_in_valid && !deliver;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_HOLDOFF && holdoff_cnt_q == HOLDOFF_CYCLES - 1) begin
            state_d = ST_ACTIVE;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            empty_reads_q <= '0;
            holdoff_cnt_q <= '0;
            state_q       <= ST_RESET;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (state_q == ST_HOLDOFF) begin
                holdoff_cnt_q <= holdoff_cnt_q + 32'd1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (empty_read && empty_reads_q != 32'hFFFF_FFFF) begin
                empty_reads_q <= empty_reads_q + 32'd1;
            end
        end
    end

    // Storage needs no reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.push_data;
        end
    end

    assign bus.push_ready    = push_ready;
    assign bus.io_uart_in_ch = deliver ? mem_q[rd_ptr_q] : EMPTY_CHAR;
    assign bus.count         = count_q;
    assign bus.empty_reads   = empty_reads_q;
endmodule

// File: tb/tb_sim_uart_in_source.sv
// Directed bench for sim_uart_in_source: per-cycle vector table for hold-off, ordering and
// no-bypass cases, plus hand sequences for full/refill and mid-stream reset.
module tb_sim_uart_in_source;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned HOLDOFF = 4;

    logic clock = 1'b0;
    logic reset_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    sim_uart_in_source_if #(.DEPTH(DEPTH)) bus ();

    sim_uart_in_source #(
        .DEPTH         (DEPTH),
        .HOLDOFF_CYCLES(HOLDOFF),
        .EMPTY_CHAR    (8'hFF)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Expected values are the pre-edge state of the cycle the inputs are applied in.
    typedef struct {
        logic        pv;
        logic [7:0]  pd;
        logic        st;
        logic [7:0]  ch;
        logic        rdy;
        logic [4:0]  cnt;
        logic [31:0] er;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic pv, input logic [7:0] pd, input logic st);
        bus.push_valid       = pv;
        bus.push_data        = pd;
        bus.io_uart_in_valid = st;
    endtask

    initial begin
        // cycle: push, data, strobe | ch, ready, count, empty_reads
        vecs[0]  = '{1'b1, 8'h41, 1'b0, 8'hFF, 1'b1, 5'd0, 32'd0};  // push during hold-off
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 5'd1, 32'd0};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 5'd1, 32'd1};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 5'd1, 32'd2};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 8'h41, 1'b1, 5'd1, 32'd3};  // hold-off over
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 8'h41, 1'b1, 5'd1, 32'd3};
        vecs[6]  = '{1'b1, 8'h68, 1'b0, 8'hFF, 1'b1, 5'd0, 32'd3};
        vecs[7]  = '{1'b1, 8'h69, 1'b0, 8'h68, 1'b1, 5'd1, 32'd3};
        vecs[8]  = '{1'b1, 8'h0A, 1'b0, 8'h68, 1'b1, 5'd2, 32'd3};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 8'h68, 1'b1, 5'd3, 32'd3};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 8'h69, 1'b1, 5'd2, 32'd3};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 8'h0A, 1'b1, 5'd1, 32'd3};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 5'd0, 32'd3};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 8'hFF, 1'b1, 5'd0, 32'd4};
        vecs[14] = '{1'b1, 8'h55, 1'b1, 8'hFF, 1'b1, 5'd0, 32'd4};  // no bypass
        vecs[15] = '{1'b0, 8'h00, 1'b1, 8'h55, 1'b1, 5'd1, 32'd5};
        vecs[16] = '{1'b0, 8'h00, 1'b0, 8'hFF, 1'b1, 5'd0, 32'd5};

        reset_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge clock);
        #1;
        check("rst_ready", 32'(bus.push_ready), 32'd0);
        check("rst_ch", 32'(bus.io_uart_in_ch), 32'hFF);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_empty_reads", bus.empty_reads, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].pv, vecs[i].pd, vecs[i].st);
            #1;
            check($sformatf("vec%0d_ch", i), 32'(bus.io_uart_in_ch), 32'(vecs[i].ch));
            check($sformatf("vec%0d_ready", i), 32'(bus.push_ready), 32'(vecs[i].rdy));
            check($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_empty_reads", i), bus.empty_reads, vecs[i].er);
            @(negedge clock);
        end

        // Fill to full, hold a 17th byte, free one slot with a strobe, refill.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(8'h10 + i), 1'b0);
            #1;
            check($sformatf("fill%0d_ready", i), 32'(bus.push_ready), 32'd1);
            check($sformatf("fill%0d_count", i), 32'(bus.count), 32'(i));
            @(negedge clock);
        end
        drive(1'b1, 8'h30, 1'b0);
        #1;
        check("full_ready", 32'(bus.push_ready), 32'd0);
        check("full_count", 32'(bus.count), 32'd16);
        check("full_head", 32'(bus.io_uart_in_ch), 32'h10);
        @(negedge clock);
        drive(1'b1, 8'h30, 1'b1);
        #1;
        check("full_pop_ready", 32'(bus.push_ready), 32'd0);
        check("full_pop_ch", 32'(bus.io_uart_in_ch), 32'h10);
        check("full_held_count", 32'(bus.count), 32'd16);
        @(negedge clock);
        drive(1'b1, 8'h30, 1'b0);
        #1;
        check("after_pop_count", 32'(bus.count), 32'd15);
        check("after_pop_ready", 32'(bus.push_ready), 32'd1);
        check("after_pop_head", 32'(bus.io_uart_in_ch), 32'h11);
        @(negedge clock);
        drive(1'b0, 8'h00, 1'b0);
        #1;
        check("refill_count", 32'(bus.count), 32'd16);
        check("refill_ready", 32'(bus.push_ready), 32'd0);
        @(negedge clock);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            #1;
            check($sformatf("drain%0d_ch", i), 32'(bus.io_uart_in_ch),
                  (i < 15) ? 32'(32'h11 + i) : 32'h30);
            @(negedge clock);
        end
        drive(1'b0, 8'h00, 1'b0);
        #1;
        check("drained_count", 32'(bus.count), 32'd0);
        check("drained_ch", 32'(bus.io_uart_in_ch), 32'hFF);
        check("drained_empty_reads", bus.empty_reads, 32'd5);
        @(negedge clock);

        // Mid-stream reset drops queued bytes and restarts the hold-off.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'hA0 + i), 1'b0);
            @(negedge clock);
        end
        drive(1'b0, 8'h00, 1'b0);
        #1;
        check("pre_reset_count", 32'(bus.count), 32'd5);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(bus.push_ready), 32'd0);
        check("mid_rst_ch", 32'(bus.io_uart_in_ch), 32'hFF);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("post_rst_count", 32'(bus.count), 32'd0);
        check("post_rst_empty_reads", bus.empty_reads, 32'd0);
        check("post_rst_ready", 32'(bus.push_ready), 32'd1);
        repeat (HOLDOFF + 1) @(negedge clock);
        drive(1'b0, 8'h00, 1'b1);
        #1;
        check("post_rst_strobe_ch", 32'(bus.io_uart_in_ch), 32'hFF);
        @(negedge clock);
        drive(1'b0, 8'h00, 1'b0);
        #1;
        check("post_rst_strobe_empty_reads", bus.empty_reads, 32'd1);
        check("post_rst_strobe_count", 32'(bus.count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
